mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameters: none; all widths fixed at RV32 (32-bit data, 5-bit register index).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled only at posedge clk.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_val  input  32  operand A, taken from register-file read port 1.
REQ-007 rs2_val  input  32  operand B, taken from register-file read port 2.
REQ-008 rd_in  input  5  destination register index for the request.
REQ-009 busy  output  1  high while an operation is in flight (CALC, FIX).
REQ-010 done  output  1  one-cycle pulse; result and rd_out valid in this cycle.
REQ-011 result  output  32  operation result, drives register-file write data.
REQ-012 rd_out  output  5  latched rd_in, drives register-file write address.
REQ-013 we_out  output  1  register-file write enable; equals done AND (rd_out != 0).

Function
REQ-014 FSM states IDLE, CALC, FIX, DONE; one state register, no other control state.
REQ-015 IDLE: start=1 at posedge -> latch funct3, rs1_val, rs2_val, rd_in; load 6-bit counter with 0; go to CALC.
REQ-016 start in CALC, FIX or DONE is ignored; latched operands are not disturbed.
REQ-017 CALC: exactly 32 cycles, one bit per cycle; counter increments each cycle; at count 31 go to FIX.
REQ-018 Multiply: shift-add on operand magnitudes into a 64-bit product; signed/unsigned per funct3 (MULH both signed, MULHSU A signed/B unsigned, MULHU both unsigned).
REQ-019 Divide: restoring shift-subtract on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
REQ-020 FIX (1 cycle): apply signs -- product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign. Select result: MUL low 32 bits, MULH/MULHSU/MULHU high 32 bits.
REQ-021 Divide by zero (B=0): quotient = 0xFFFFFFFF (DIV and DIVU); remainder = A.
REQ-022 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
REQ-023 Special cases REQ-021/022 take the same fixed latency as normal operations.
REQ-024 DONE (1 cycle): done=1, result and rd_out valid; next state IDLE unconditionally.
REQ-025 Fixed latency: start accepted at edge k -> done high for exactly the cycle between edges k+34 and k+35.
REQ-026 A new start is accepted no earlier than edge k+35, i.e. the first edge in IDLE after DONE.
REQ-027 result and rd_out hold their last values outside DONE; consumers qualify them with done.
REQ-028 busy=1 in CALC and FIX only; done and busy are never high together.

Reset
REQ-029 rst_n=0 at posedge -> state IDLE, counter 0, busy=0, done=0, we_out=0, result=0, rd_out=0, all datapath registers 0.
REQ-030 Reset during CALC, FIX or DONE aborts the operation: no done pulse and no we_out for the aborted request.
REQ-031 start is ignored in any cycle in which rst_n=0.

Verification
REQ-032 MUL A=7, B=0xFFFFFFFD (-3) -> done exactly 34 cycles after accept, result=0xFFFFFFEB, we_out=1 with rd_out=5.
REQ-033 MULH A=B=0x80000000 -> result=0x40000000; MULHU A=B=0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; REM A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFF.
REQ-035 DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0.
REQ-036 Second start pulsed 10 cycles after accept with different operands -> ignored; first result unchanged; rd_in=0 request -> done=1, we_out=0.
REQ-037 rst_n=0 for one cycle 20 cycles into CALC -> busy=0 next cycle, no done within 40 cycles; a subsequent start completes normally.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle for 32 cycles,
// followed by a sign-fix cycle and a one-cycle done/write-back pulse.
module mdu_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we_out
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic        neg_a_q;
    logic        div0_q;
    logic        ovf_q;
    logic [4:0]  rd_q;
    logic [31:0] fix_q;
    logic        busy_q;
    logic        done_q;
    logic        we_q;
    logic [31:0] result_q;
    logic [4:0]  rd_out_q;

    // Operand decode at accept time, straight from the register-file read ports.
    logic        sgn_a_in;
    logic        sgn_b_in;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic        ovf_in;

    assign sgn_a_in = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                      (funct3 == F_DIV)  || (funct3 == F_REM);
    assign sgn_b_in = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    assign neg_a_in = sgn_a_in && rs1_val[31];
    assign neg_b_in = sgn_b_in && rs2_val[31];
    assign mag_a_in = neg_a_in ? -rs1_val : rs1_val;
    assign mag_b_in = neg_b_in ? -rs2_val : rs2_val;
    assign ovf_in   = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                      (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    logic [63:0] mul_d;

    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_d   = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits in}.
    logic [32:0] rem_try;
    logic        div_ge;
    logic [31:0] rem_new;
    logic [63:0] div_d;

    assign rem_try = {acc_q[63:32], acc_q[31]};
    assign div_ge  = rem_try >= {1'b0, opnd_q};
    assign rem_new = div_ge ? 32'(rem_try - {1'b0, opnd_q}) : rem_try[31:0];
    assign div_d   = {rem_new, acc_q[30:0], div_ge};

    logic [63:0] acc_d;
    assign acc_d = op_q[2] ? div_d : mul_d;

    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] fix_d;

    assign prod_s = neg_q   ? -acc_q         : acc_q;
    assign quo_s  = neg_q   ? -acc_q[31:0]   : acc_q[31:0];
    assign rem_s  = neg_a_q ? -acc_q[63:32]  : acc_q[63:32];

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        fix_d = '0;
        case (op_q)
            F_MUL:                      fix_d = prod_s[31:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_d = prod_s[63:32];
            F_DIV, F_DIVU:              fix_d = div0_q ? 32'hFFFF_FFFF :
                                                (ovf_q ? 32'h8000_0000 : quo_s);
            default:                    fix_d = div0_q ? a_q : (ovf_q ? 32'h0 : rem_s);
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            fix_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            busy_q <= (state_q == CALC) || (state_q == FIX);
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        a_q     <= rs1_val;
                        opnd_q  <= funct3[2] ? mag_b_in : mag_a_in;
                        acc_q   <= {32'd0, funct3[2] ? mag_a_in : mag_b_in};
                        neg_q   <= neg_a_in ^ neg_b_in;
                        neg_a_q <= neg_a_in;
                        div0_q  <= (rs2_val == 32'd0);
                        ovf_q   <= ovf_in;
                        rd_q    <= rd_in;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    fix_q   <= fix_d;
                    state_q <= DONE;
                end
                default: begin
                    result_q <= fix_q;
                    rd_out_q <= rd_q;
                    done_q   <= 1'b1;
                    we_q     <= (rd_q != 5'd0);
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we_out = we_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomised bench for mdu_iter: expected write-backs are queued
// at issue and compared when done pulses, together with latency and handshakes.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    mdu_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M reference, independent of the iterative datapath.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ps;
        logic        [63:0] pu;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic               ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sbv));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sbv));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request, optionally pulse a second start inj cycles after accept,
    // then watch for the done pulse and compare against the queued expectation.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int inj);
        int   got;
        exp_t e;
        @(negedge clk);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        sb.push_back('{exp_res, rd, rd != 5'd0});
        @(posedge clk);
        got = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                rs1_val = ~a;
                rs2_val = ~b;
                rd_in   = ~rd;
            end
            if (i == inj) begin
                start   = 1'b1;
                funct3  = 3'd0;
                rs1_val = 32'd1;
                rs2_val = 32'd1;
                rd_in   = 5'd9;
            end
            if (i == inj + 1) start = 1'b0;
            if (i == 16) check({tag, "_busy_calc"}, busy, 1);
            if (done && got < 0) begin
                got = i;
                check({tag, "_busy_in_done"}, busy, 0);
                if (sb.size() == 0) begin
                    check({tag, "_queue_empty"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_result"}, result, e.res);
                    check({tag, "_rd_out"}, rd_out, e.rd);
                    check({tag, "_we_out"}, we_out, e.we);
                end
            end else if (got >= 0) begin
                check({tag, "_done_one_cycle"}, done, 0);
                break;
            end
        end
        check({tag, "_latency"}, got, 34);
    endtask

    int n_done;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        funct3  = 3'd0;
        rs1_val = 32'd5;
        rs2_val = 32'd6;
        rd_in   = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", we_out, 0);
        check("rst_result", result, 0);
        check("rst_rd_out", rd_out, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_reset_ignored", busy, 0);

        run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, -1);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, -1);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, -1);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, -1);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd4, 32'd2, -1);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, -1);
        run_op("div_by0", 3'd4, 32'd7, 32'd0, 5'd7, 32'hFFFF_FFFF, -1);
        run_op("rem_by0", 3'd6, 32'd7, 32'd0, 5'd8, 32'd7, -1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, -1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0, -1);
        run_op("restart_ignored_rd0", 3'd4, 32'hFFFF_FFCE, 32'd3, 5'd0, 32'hFFFF_FFF0, 10);

        for (int f = 0; f < 8; f++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (f >= 4) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
            run_op($sformatf("rand_f%0d", f), 3'(f), ra, rb, 5'(f + 12), ref_mdu(3'(f), ra, rb), -1);
        end

        // Abort an operation with a one-cycle reset 20 cycles into CALC.
        @(negedge clk);
        funct3  = 3'd3;
        rs1_val = 32'h1234_5678;
        rs2_val = 32'h9ABC_DEF0;
        rd_in   = 5'd20;
        start   = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 20) rst_n = 1'b0;
            if (i == 21) begin
                check("abort_busy", busy, 0);
                check("abort_result", result, 0);
                rst_n = 1'b1;
            end
        end
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || we_out) n_done++;
        end
        check("abort_no_done", n_done, 0);

        run_op("after_abort", 3'd0, 32'd123, 32'd456, 5'd31, 32'd56088, -1);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
